// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Purpose : Bundles the two producer handshakes, the grant flags and the FIFO
//           write side that fifo_wr_arbiter sits in the middle of.
// Modports:
//   slave  - the arbiter: takes req/din/fifo_full, drives ack/grant/fifo_wt_en/fifo_din
//   master - the surroundings (producers + FIFO): the opposite directions
// Signals : req0/din0/ack0, req1/din1/ack1, grant0/grant1,
//           fifo_full, fifo_wt_en, fifo_din
// Optional: ARB_STATS_EN adds beat_cnt0, beat_cnt1, stall_cnt (16b, from arbiter)
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              req0;
  logic [DATA_W-1:0] din0;
  logic              ack0;
  logic              req1;
  logic [DATA_W-1:0] din1;
  logic              ack1;
  logic              grant0;
  logic              grant1;
  logic              fifo_full;
  logic              fifo_wt_en;
  logic [DATA_W-1:0] fifo_din;
`ifdef ARB_STATS_EN
  logic [15:0]       beat_cnt0;
  logic [15:0]       beat_cnt1;
  logic [15:0]       stall_cnt;
`endif

  modport slave (
    input  req0, din0, req1, din1, fifo_full,
    output ack0, ack1, grant0, grant1, fifo_wt_en, fifo_din
`ifdef ARB_STATS_EN
    , output beat_cnt0, beat_cnt1, stall_cnt
`endif
  );

  modport master (
    output req0, din0, req1, din1, fifo_full,
    input  ack0, ack1, grant0, grant1, fifo_wt_en, fifo_din
`ifdef ARB_STATS_EN
    , input beat_cnt0, beat_cnt1, stall_cnt
`endif
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Purpose : Shares one FIFO write port between two producers using a
//           round-robin burst scheduler. An owner keeps the port for up to
//           BURST_LEN accepted beats, then yields if the other side is waiting.
//           Writes are always gated by fifo_full.
// Ports   :
//   clk  - system clock, all state on posedge
//   rst  - asynchronous, active-high reset
//   bus  - fifo_wr_arbiter_if.slave (producer handshakes, grants, FIFO write side)
// Params  : DATA_W (data width), BURST_LEN (beats per ownership, >= 1)
// Optional: define ARB_STATS_EN for beat_cnt0/beat_cnt1/stall_cnt counters.
//
// state | meaning
// IDLE  | nobody owns the port
// OWN0  | producer 0 owns the port
// OWN1  | producer 1 owns the port
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_rr_ptr;
  logic [CNT_W-1:0] r_burst_cnt;
  logic             r_grant0;
  logic             r_grant1;

  state_t           w_state_nxt;
  state_t           w_other_st;
  logic             w_rr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_own0;
  logic             w_own1;
  logic             w_owner_req;
  logic             w_other_req;
  logic             w_beat;
  logic             w_burst_done;

  assign w_own0       = (r_state == OWN0);
  assign w_own1       = (r_state == OWN1);
  assign w_owner_req  = (w_own0 & bus.req0) | (w_own1 & bus.req1);
  assign w_other_req  = (w_own0 & bus.req1) | (w_own1 & bus.req0);
  assign w_other_st   = w_own0 ? OWN1 : OWN0;
  // Beat comes straight from registered state, so it drops the moment rst hits.
  assign w_beat       = w_owner_req & ~bus.fifo_full;
  assign w_cnt_inc    = r_burst_cnt + CNT_W'(1);
  assign w_burst_done = (w_cnt_inc == CNT_W'(BURST_LEN));

  assign bus.fifo_wt_en = w_beat;
  assign bus.ack0       = w_beat & w_own0;
  assign bus.ack1       = w_beat & w_own1;
  assign bus.fifo_din   = !w_beat ? '0 : (w_own0 ? bus.din0 : bus.din1);
  assign bus.grant0     = r_grant0;
  assign bus.grant1     = r_grant1;

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_cnt_nxt   = r_burst_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (bus.req0 && bus.req1) begin
          w_state_nxt = r_rr_ptr ? OWN1 : OWN0;
        end else if (bus.req0) begin
          w_state_nxt = OWN0;
        end else if (bus.req1) begin
          w_state_nxt = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (!w_owner_req) begin
          w_state_nxt = w_other_req ? w_other_st : IDLE;
          w_cnt_nxt   = '0;
          w_rr_nxt    = w_own0;
        end else if (w_beat) begin
          if (w_burst_done) begin
            // Burst exhausted: hand over without a bubble, or restart the
            // burst in place when the other producer is quiet.
            w_cnt_nxt = '0;
            if (w_other_req) begin
              w_state_nxt = w_other_st;
              w_rr_nxt    = w_own0;
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        // FIFO full with owner requesting: everything holds.
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= 1'b0;
      r_burst_cnt <= '0;
      r_grant0    <= 1'b0;
      r_grant1    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_burst_cnt <= w_cnt_nxt;
      r_grant0    <= (w_state_nxt == OWN0);
      r_grant1    <= (w_state_nxt == OWN1);
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] r_beat_cnt0;
  logic [15:0] r_beat_cnt1;
  logic [15:0] r_stall_cnt;

  // Counters wrap naturally at 16'hFFFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt0 <= '0;
      r_beat_cnt1 <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (bus.ack0) r_beat_cnt0 <= r_beat_cnt0 + 16'd1;
      if (bus.ack1) r_beat_cnt1 <= r_beat_cnt1 + 16'd1;
      if (w_owner_req && bus.fifo_full) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.beat_cnt0 = r_beat_cnt0;
  assign bus.beat_cnt1 = r_beat_cnt1;
  assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed bench for fifo_wr_arbiter (DATA_W=8, BURST_LEN=4, 20ns clock).
// Producers are modelled as data queues; the expected FIFO write stream
// ({producer, data}) is pushed when a scenario is set up and popped on every
// observed write. Define ARB_STATS_EN to also check the statistics counters.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_W(DATA_W)) bus ();

  fifo_wr_arbiter #(.DATA_W(DATA_W), .BURST_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [8:0] exp_q[$];

  int   cyc = 0;
  int   n_ack0, n_ack1, first_beat, last_beat;
  logic s_ack0, s_ack1, s_grant0, s_grant1, s_wt_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_prod();
    bus.req0 = (q0.size() != 0);
    bus.din0 = (q0.size() != 0) ? q0[0] : 8'h00;
    bus.req1 = (q1.size() != 0);
    bus.din1 = (q1.size() != 0) ? q1[0] : 8'h00;
  endtask

  task automatic expect_wr(input logic src, input logic [7:0] d);
    exp_q.push_back({src, d});
  endtask

  task automatic clear_counts();
    n_ack0     = 0;
    n_ack1     = 0;
    first_beat = -1;
    last_beat  = -1;
  endtask

  // One clock: sample and score at negedge, then advance producers after posedge.
  task automatic tick();
    logic [8:0] e;
    @(negedge clk);
    cyc++;
    s_ack0   = bus.ack0;
    s_ack1   = bus.ack1;
    s_grant0 = bus.grant0;
    s_grant1 = bus.grant1;
    s_wt_en  = bus.fifo_wt_en;
    chk("inv_full_write", {31'd0, bus.fifo_wt_en & bus.fifo_full}, 32'd0);
    chk("inv_both_ack",   {31'd0, bus.ack0 & bus.ack1}, 32'd0);
    chk("inv_both_grant", {31'd0, bus.grant0 & bus.grant1}, 32'd0);
    if (bus.fifo_wt_en) begin
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
      if (bus.ack0) n_ack0++;
      if (bus.ack1) n_ack1++;
      chk("write_has_ack", {31'd0, bus.ack0 | bus.ack1}, 32'd1);
      chk("sb_unexpected_write", exp_q.size(), (exp_q.size() == 0) ? 32'd1 : exp_q.size());
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_src_data", {23'd0, bus.ack1, bus.fifo_din}, {23'd0, e});
      end
    end else begin
      chk("idle_outputs", {22'd0, bus.ack0, bus.ack1, bus.fifo_din}, 32'd0);
    end
    @(posedge clk);
    #1;
    if (s_ack0 && q0.size() != 0) void'(q0.pop_front());
    if (s_ack1 && q1.size() != 0) void'(q1.pop_front());
    drive_prod();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && (q0.size() + q1.size() + exp_q.size()) != 0; i++) tick();
    chk(tag, q0.size() + q1.size() + exp_q.size(), 32'd0);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    q0.delete();
    q1.delete();
    exp_q.delete();
    bus.fifo_full = 1'b0;
    drive_prod();
    #20;
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.fifo_full = 1'b0;
    q0.delete();
    q1.delete();
    drive_prod();
    clear_counts();
    @(posedge clk);
    #1;

    // 1: both requesting while reset held, producer 0 wins after release
    q0.push_back(8'hA1);
    q1.push_back(8'hB1);
    expect_wr(1'b0, 8'hA1);
    expect_wr(1'b1, 8'hB1);
    drive_prod();
    #2;
    chk("s1_outputs_in_reset",
        {20'd0, bus.grant0, bus.grant1, bus.ack0, bus.ack1, bus.fifo_wt_en, bus.fifo_din}, 32'd0);
`ifdef ARB_STATS_EN
    chk("s1_stats_in_reset", {bus.beat_cnt0, bus.beat_cnt1 | bus.stall_cnt}, 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();
    chk("s1_grant0_before_edge", {31'd0, s_grant0}, 32'd0);
    tick();
    chk("s1_grant0_after_edge", {30'd0, s_grant0, s_grant1}, 32'd2);
    drain("s1_drain");

    // 2: single producer, 6 beats in order, then back to idle
    reset_dut();
    clear_counts();
    for (int i = 1; i <= 6; i++) begin
      q0.push_back(8'(i));
      expect_wr(1'b0, 8'(i));
    end
    drive_prod();
    tick();
    chk("s2_grant_latency_0", {31'd0, s_grant0}, 32'd0);
    tick();
    chk("s2_grant_latency_1", {31'd0, s_grant0}, 32'd1);
    drain("s2_drain");
    chk("s2_ack0_count", n_ack0, 32'd6);
    chk("s2_ack1_count", n_ack1, 32'd0);
    tick();
    chk("s2_grant_req_low", {31'd0, s_grant0}, 32'd1);
    tick();
    chk("s2_grant_idle", {30'd0, s_grant0, s_grant1}, 32'd0);

    // 3: both producers saturating, alternating bursts of 4 with no bubble
    reset_dut();
    clear_counts();
    for (int i = 0; i < 8; i++) begin
      q0.push_back(8'h10 + 8'(i));
      q1.push_back(8'h20 + 8'(i));
    end
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) expect_wr(1'b0, 8'h10 + 8'(b * 4 + i));
      for (int i = 0; i < 4; i++) expect_wr(1'b1, 8'h20 + 8'(b * 4 + i));
    end
    drive_prod();
    drain("s3_drain");
    chk("s3_ack0_count", n_ack0, 32'd8);
    chk("s3_ack1_count", n_ack1, 32'd8);
    chk("s3_no_bubble_span", last_beat - first_beat + 1, 32'd16);
    tick();
    tick();

    // 4: FIFO full stall after beat 2 of producer 0's burst
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(8'h30 + 8'(i));
      expect_wr(1'b0, 8'h30 + 8'(i));
    end
    q1.push_back(8'h40);
    q1.push_back(8'h41);
    expect_wr(1'b1, 8'h40);
    expect_wr(1'b1, 8'h41);
    drive_prod();
    for (int i = 0; i < 20 && n_ack0 < 2; i++) tick();
    chk("s4_two_beats_before_full", n_ack0, 32'd2);
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s4_stall_no_write", {30'd0, s_wt_en, s_ack0}, 32'd0);
      chk("s4_stall_keeps_grant", {30'd0, s_grant0, s_grant1}, 32'd2);
    end
    bus.fifo_full = 1'b0;
    drain("s4_drain");
    chk("s4_ack0_count", n_ack0, 32'd4);
    chk("s4_ack1_count", n_ack1, 32'd2);
`ifdef ARB_STATS_EN
    // 6: counters accumulated over scenarios 3 and 4
    chk("s6_beat_cnt0", {16'd0, bus.beat_cnt0}, 32'd12);
    chk("s6_beat_cnt1", {16'd0, bus.beat_cnt1}, 32'd10);
    chk("s6_stall_cnt", {16'd0, bus.stall_cnt}, 32'd3);
`endif

    // 5: async reset mid OWN1 burst, round-robin pointer back to 0
    reset_dut();
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      q1.push_back(8'h50 + 8'(i));
      expect_wr(1'b1, 8'h50 + 8'(i));
    end
    drive_prod();
    for (int i = 0; i < 20 && n_ack1 < 1; i++) tick();
    chk("s5_first_beat_done", n_ack1, 32'd1);
    #4;
    chk("s5_beat2_active", {31'd0, bus.fifo_wt_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("s5_async_drop", {29'd0, bus.fifo_wt_en, bus.ack1, bus.grant1}, 32'd0);
`ifdef ARB_STATS_EN
    chk("s6_stats_cleared", {bus.beat_cnt0, bus.beat_cnt1 | bus.stall_cnt}, 32'd0);
`endif
    q0.delete();
    q1.delete();
    exp_q.delete();
    drive_prod();
    #9;
    rst = 1'b0;
    q0.push_back(8'h60);
    q1.push_back(8'h61);
    expect_wr(1'b0, 8'h60);
    expect_wr(1'b1, 8'h61);
    drive_prod();
    tick();
    chk("s5_rr_ptr_zero", {30'd0, s_grant0, s_grant1}, 32'd2);
    drain("s5_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
